// File: rtl/rejestr_pkg.sv
// rejestr_pkg: shared types and constants for the rejestr shift register and its
// command sequencer.
//   op_t    - command opcodes (LOAD, SHL, SHR, ROTL)
//   state_t - sequencer FSM states
//   MODE_*  - register mode encodings as seen on {l, r}
package rejestr_pkg;

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpShl  = 2'b01,
        OpShr  = 2'b10,
        OpRotl = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StShift = 2'b10,
        StResp  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TO_MSB = 2'b01;
    localparam logic [1:0] MODE_TO_LSB = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    // Register mode that carries out one step of the given opcode.
    function automatic logic [1:0] op_mode(input op_t op);
        logic [1:0] mode;
        mode = MODE_HOLD;
        unique case (op)
            OpLoad:  mode = MODE_LOAD;
            OpShl:   mode = MODE_TO_MSB;
            OpShr:   mode = MODE_TO_LSB;
            OpRotl:  mode = MODE_TO_MSB;
            default: mode = MODE_HOLD;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/rejestr_ctrl_if.sv
// rejestr_ctrl_if: command and result handshakes of the rejestr sequencer.
//   cmd_*  - command channel (valid/ready), opcode, step count - 1, load data, fill bit
//   res_*  - result channel (valid/ready), result data
// Modports: master = command issuer / result consumer, slave = sequencer.
interface rejestr_ctrl_if;
    import rejestr_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    op_t        cmd_op;
    logic [2:0] cmd_amt;
    logic [7:0] cmd_data;
    logic       cmd_fill;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill, res_ready,
        output cmd_ready, res_valid, res_data
    );

endinterface

// File: rtl/rejestr.sv
// rejestr: 8-bit universal shift register, no reset.
//   c      - clock
//   l, r   - mode: 00 hold, 01 toward MSB, 10 toward LSB, 11 load d
//   i      - serial input bit entering at the vacated end
//   d      - parallel load value
//   q      - register contents
module rejestr
    import rejestr_pkg::*;
(
    input  logic       c,
    input  logic       l,
    input  logic       r,
    input  logic       i,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge c) begin
        unique case ({l, r})
            MODE_LOAD:   q <= d;
            MODE_TO_MSB: q <= {q[6:0], i};
            MODE_TO_LSB: q <= {i, q[7:1]};
            default:     q <= q;
        endcase
    end

endmodule

// File: rtl/rejestr_sys.sv
// rejestr_sys: sequencer plus shift register with flat handshake ports.
//   c, rst            - clock, synchronous active-high reset
//   cmd_*_i/o         - command channel
//   res_*_i/o         - result channel
module rejestr_sys
    import rejestr_pkg::*;
(
    input  logic       c,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [2:0] cmd_amt_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_fill_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_data_o
);

    rejestr_ctrl_if bus ();

    logic [7:0] q;
    logic [7:0] reg_d;
    logic       reg_i;
    logic       reg_l;
    logic       reg_r;

    assign bus.cmd_valid = cmd_valid_i;
    assign bus.cmd_op    = op_t'(cmd_op_i);
    assign bus.cmd_amt   = cmd_amt_i;
    assign bus.cmd_data  = cmd_data_i;
    assign bus.cmd_fill  = cmd_fill_i;
    assign bus.res_ready = res_ready_i;
    assign cmd_ready_o   = bus.cmd_ready;
    assign res_valid_o   = bus.res_valid;
    assign res_data_o    = bus.res_data;

    rejestr_ctrl u_ctrl (
        .c     (c),
        .rst   (rst),
        .bus   (bus),
        .q_in  (q),
        .reg_d (reg_d),
        .reg_i (reg_i),
        .reg_l (reg_l),
        .reg_r (reg_r)
    );

    rejestr u_reg (
        .c (c),
        .l (reg_l),
        .r (reg_r),
        .i (reg_i),
        .d (reg_d),
        .q (q)
    );

endmodule

// File: rtl/rejestr_ctrl.sv
// rejestr_ctrl: command sequencer in front of the rejestr shift register.
// Accepts LOAD / SHL / SHR / ROTL commands, drives the register mode lines for the
// required number of cycles and returns the resulting contents.
//   c, rst          - clock, synchronous active-high reset
//   bus (slave)     - command and result handshakes
//   q_in            - register output q
//   reg_d/i/l/r     - register inputs d, i, l, r
module rejestr_ctrl
    import rejestr_pkg::*;
(
    input  logic       c,
    input  logic       rst,
    rejestr_ctrl_if.slave bus,
    input  logic [7:0] q_in,
    output logic [7:0] reg_d,
    output logic       reg_i,
    output logic       reg_l,
    output logic       reg_r
);

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [1:0] mode_q;
    logic [7:0] reg_d_q;
    logic       fill_q;
    logic       rot_q;
    logic       cmd_ready_q;
    logic       res_valid_q;

    always_ff @(posedge c) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            mode_q      <= MODE_HOLD;
            reg_d_q     <= 8'h00;
            fill_q      <= 1'b0;
            rot_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        cnt_q       <= bus.cmd_amt;
                        mode_q      <= op_mode(bus.cmd_op);
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_op == OpLoad) begin
                            state_q <= StLoad;
                            reg_d_q <= bus.cmd_data;
                        end else begin
                            state_q <= StShift;
                            // Rotate feeds q[7] back live; the fill bit is only for shifts.
                            rot_q   <= (bus.cmd_op == OpRotl);
                            fill_q  <= (bus.cmd_op == OpRotl) ? 1'b0 : bus.cmd_fill;
                        end
                    end
                end
                StLoad: begin
                    state_q     <= StResp;
                    mode_q      <= MODE_HOLD;
                    reg_d_q     <= 8'h00;
                    res_valid_q <= 1'b1;
                end
                StShift: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= StResp;
                        mode_q      <= MODE_HOLD;
                        fill_q      <= 1'b0;
                        rot_q       <= 1'b0;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    if (bus.res_ready) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mode_q      <= MODE_HOLD;
                    reg_d_q     <= 8'h00;
                    fill_q      <= 1'b0;
                    rot_q       <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Rotate must see the bit shifted out on this very step, so it bypasses the register.
    always_comb begin
        reg_i = rot_q ? q_in[7] : fill_q;
    end

    assign reg_l         = mode_q[1];
    assign reg_r         = mode_q[0];
    assign reg_d         = reg_d_q;
    // Held low while reset is asserted, not just from the edge after.
    assign bus.cmd_ready = cmd_ready_q & ~rst;
    assign bus.res_valid = res_valid_q;
    // The register holds in RESP, so the live value is stable for the whole response.
    assign bus.res_data  = q_in;

endmodule
